paddle_ai_driver: RTL

- Computer opponent for the pong paddle. It generates the left/right button signals that the player paddle-state block consumes, which makes it the input-side end of that interface.
- It compares the ball column `target_x` with the paddle position fed back from the player block and emits one press/release cycle per single-step move.
- It uses the player block's `action` output as a move acknowledge.
- It sits between the ball logic and a player paddle-state instance, replacing the physical buttons.

---
 rtl/pong_pkg.sv | 30 +++
 rtl/ai_target_cmp.sv | 32 +++
 rtl/paddle_ai_driver.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared pong definitions: move-report codes, AI direction/state enums and
// default playfield dimensions.
package pong_pkg;

  localparam int FIELD_BIT_WIDTH = 3;
  localparam int PADDLE_SIZE     = 2;

  localparam logic [1:0] ACT_NONE  = 2'b00;
  localparam logic [1:0] ACT_RIGHT = 2'b01;
  localparam logic [1:0] ACT_LEFT  = 2'b10;

  typedef enum logic {
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS,
    S_RELEASE,
    S_COOLDOWN
  } ai_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ai_target_cmp.sv
// Decides whether the paddle must step left/right to cover the ball column,
// and whether the column already lies within the paddle span.
module ai_target_cmp
  import pong_pkg::*;
#(
  parameter int BIT_WIDTH = FIELD_BIT_WIDTH,
  parameter int SIZE      = PADDLE_SIZE
) (
  input  logic [BIT_WIDTH-1:0] target_x,
  input  logic [BIT_WIDTH-1:0] state_left,
  output logic                 need_left,
  output logic                 need_right,
  output logic                 in_span
);

  localparam int W = BIT_WIDTH + 1;
  localparam logic [W-1:0] MAXPOS = W'((1 << BIT_WIDTH) - SIZE);

  logic [W-1:0] tx;
  logic [W-1:0] sl;
  logic [W-1:0] right_edge;

  // One extra bit keeps right_edge from wrapping at the far wall.
  assign tx         = {1'b0, target_x};
  assign sl         = {1'b0, state_left};
  assign right_edge = sl + W'(SIZE - 1);

  assign need_left  = (tx < sl) && (sl != '0);
  assign need_right = (tx > right_edge) && (sl != MAXPOS);
  assign in_span    = (sl <= tx) && (tx <= right_edge);

endmodule

// File: rtl/paddle_ai_driver.sv
// Computer opponent: emulates the left/right buttons of a player paddle block,
// issuing one press/release per single-column step toward the ball.
module paddle_ai_driver
  import pong_pkg::*;
#(
  parameter int BIT_WIDTH      = FIELD_BIT_WIDTH,
  parameter int SIZE           = PADDLE_SIZE,
  parameter int HOLD_MAX       = 4,
  parameter int RELEASE_CYCLES = 2,
  parameter int COOLDOWN       = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [BIT_WIDTH-1:0] target_x,
  input  logic [BIT_WIDTH-1:0] state_left,
  input  logic [1:0]           action,
  output logic                 left,
  output logic                 right,
  output logic                 busy,
  output logic                 aligned,
  output logic                 ack_timeout
);

  // At least one release cycle is needed so the player re-arms its click latch.
  localparam int HOLD_CYC = (HOLD_MAX < 1) ? 1 : HOLD_MAX;
  localparam int REL_CYC  = (RELEASE_CYCLES < 1) ? 1 : RELEASE_CYCLES;
  localparam int CNT_MAX  = max3(HOLD_CYC, REL_CYC, COOLDOWN);
  localparam int CW       = $clog2(CNT_MAX + 1);

  ai_state_t     state;
  dir_t          dir;
  logic [CW-1:0] cnt;
  logic          need_left;
  logic          need_right;
  logic          in_span;
  logic          ack;

  ai_target_cmp #(
    .BIT_WIDTH (BIT_WIDTH),
    .SIZE      (SIZE)
  ) u_cmp (
    .target_x   (target_x),
    .state_left (state_left),
    .need_left  (need_left),
    .need_right (need_right),
    .in_span    (in_span)
  );

  assign ack = (dir == DIR_LEFT) ? (action == ACT_LEFT) : (action == ACT_RIGHT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      dir         <= DIR_LEFT;
      cnt         <= '0;
      left        <= 1'b0;
      right       <= 1'b0;
      busy        <= 1'b0;
      aligned     <= 1'b0;
      ack_timeout <= 1'b0;
    end else begin
      aligned     <= in_span;
      ack_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          left  <= 1'b0;
          right <= 1'b0;
          if (en && need_left) begin
            dir   <= DIR_LEFT;
            left  <= 1'b1;
            cnt   <= CW'(1);
            busy  <= 1'b1;
            state <= S_PRESS;
          end else if (en && need_right) begin
            dir   <= DIR_RIGHT;
            right <= 1'b1;
            cnt   <= CW'(1);
            busy  <= 1'b1;
            state <= S_PRESS;
          end
        end
        S_PRESS: begin
          // Acknowledge wins over a simultaneous disable; only a genuine hold expiry reports timeout.
          if (ack || !en || (cnt == CW'(HOLD_CYC))) begin
            left        <= 1'b0;
            right       <= 1'b0;
            ack_timeout <= !ack && en;
            cnt         <= CW'(1);
            state       <= S_RELEASE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RELEASE: begin
          if (cnt == CW'(REL_CYC)) begin
            if (COOLDOWN == 0) begin
              cnt   <= '0;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              cnt   <= CW'(1);
              state <= S_COOLDOWN;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_COOLDOWN: begin
          if (cnt == CW'(COOLDOWN)) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          left  <= 1'b0;
          right <= 1'b0;
          busy  <= 1'b0;
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
